noc_ni_packetizer: RTL



---
 rtl/noc_ni_packetizer_pkg.sv | 39 +++
 rtl/noc_ni_packetizer_slice.sv | 50 +++++
 rtl/noc_ni_packetizer.sv | 151 +++++++++++++++
 3 files changed

// File: rtl/noc_ni_packetizer_pkg.sv
// +----------------------------------------------------------------------------+
// | noc_ni_packetizer_pkg : shared NoC types for the NI transmit packetizer    |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
`default_nettype none

package noc_ni_packetizer_pkg;

  localparam int Noc_ID_X_Width = 4;
  localparam int Noc_ID_Y_Width = 4;

  localparam int NOC_PLD_W    = 32;
  localparam int NOC_VC_NUM   = 2;
  localparam int NOC_MAX_LEN  = 15;
  localparam int NOC_LEN_W    = $clog2(NOC_MAX_LEN + 1);
  localparam int NOC_PKT_ID_W = 8;

  typedef enum logic [1:0] {
    FLIT_HEAD_TAIL = 2'b00,
    FLIT_HEAD      = 2'b01,
    FLIT_BODY      = 2'b10,
    FLIT_TAIL      = 2'b11
  } flit_type_e;

  // Declared MSB first so that dst_x lands in the least significant bits.
  typedef struct packed {
    logic [NOC_PKT_ID_W-1:0]   pkt_id;
    logic [NOC_LEN_W-1:0]      len;
    logic [Noc_ID_Y_Width-1:0] src_y;
    logic [Noc_ID_X_Width-1:0] src_x;
    logic [Noc_ID_Y_Width-1:0] dst_y;
    logic [Noc_ID_X_Width-1:0] dst_x;
  } head_hdr_t;

  typedef logic [$clog2(NOC_VC_NUM)-1:0] vc_idx_t;

endpackage

`default_nettype wire

// File: rtl/noc_ni_packetizer_slice.sv
// +----------------------------------------------------------------------------+
// | noc_flit_out_slice : 1-entry registered valid/ready slice for flits + VC   |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
`default_nettype none

module noc_flit_out_slice #(
  parameter int DATA_W = 34,
  parameter int VC_W   = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_valid,
  output logic              o_ready,
  input  logic [DATA_W-1:0] i_data,
  input  logic [VC_W-1:0]   i_vc,
  output logic              o_valid,
  input  logic              i_ready,
  output logic [DATA_W-1:0] o_data,
  output logic [VC_W-1:0]   o_vc
);

  logic              r_valid;
  logic [DATA_W-1:0] r_data;
  logic [VC_W-1:0]   r_vc;

  // The entry may be refilled on the same edge it drains.
  assign o_ready = !r_valid || i_ready;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_valid <= 1'b0;
      r_data  <= '0;
      r_vc    <= '0;
    end else if (o_ready) begin
      r_valid <= i_valid;
      if (i_valid) begin
        r_data <= i_data;
        r_vc   <= i_vc;
      end
    end
  end

  assign o_valid = r_valid;
  assign o_data  = r_data;
  assign o_vc    = r_vc;

endmodule

`default_nettype wire

// File: rtl/noc_ni_packetizer.sv
// +----------------------------------------------------------------------------+
// | noc_ni_packetizer : serialises a descriptor + payload into wormhole flits  |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
`default_nettype none

module noc_ni_packetizer
  import noc_ni_packetizer_pkg::*;
#(
  parameter int PLD_W    = 32,
  parameter int VC_NUM   = 2,
  parameter int MAX_LEN  = 15,
  parameter int PKT_ID_W = 8,
  localparam int LEN_W   = $clog2(MAX_LEN + 1),
  localparam int VC_W    = (VC_NUM > 1) ? $clog2(VC_NUM) : 1
) (
  input  logic                      noc_clk,
  input  logic                      noc_rst,
  input  logic [Noc_ID_X_Width-1:0] id_x,
  input  logic [Noc_ID_Y_Width-1:0] id_y,
  input  logic                      msg_valid,
  output logic                      msg_ready,
  input  logic [Noc_ID_X_Width-1:0] msg_dst_x,
  input  logic [Noc_ID_Y_Width-1:0] msg_dst_y,
  input  logic [VC_W-1:0]           msg_vc,
  input  logic [LEN_W-1:0]          msg_len,
  input  logic                      pld_valid,
  output logic                      pld_ready,
  input  logic [PLD_W-1:0]          pld_data,
  output logic                      flit_valid,
  input  logic                      flit_ready,
  output logic [PLD_W+1:0]          flit_data,
  output logic [VC_W-1:0]           flit_vc,
  input  logic [VC_NUM-1:0]         vc_ready,
  output logic                      busy
);

  localparam int C_HDR_W = 2*Noc_ID_X_Width + 2*Noc_ID_Y_Width + LEN_W + PKT_ID_W;

  generate
    if (C_HDR_W > PLD_W) begin : g_hdr_width_check
      $error("noc_ni_packetizer: head header (%0d bits) exceeds PLD_W (%0d)", C_HDR_W, PLD_W);
    end
  endgenerate

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_BODY = 1'b1
  } state_e;

  state_e               r_state;
  state_e               w_state_nxt;
  logic [PKT_ID_W-1:0]  r_pkt_id;
  logic [PKT_ID_W-1:0]  w_pkt_id_nxt;
  logic [VC_W-1:0]      r_vc;
  logic [VC_W-1:0]      w_vc_nxt;
  logic [LEN_W-1:0]     r_remaining;
  logic [LEN_W-1:0]     w_remaining_nxt;

  logic                 w_slot_free;
  logic                 w_in_valid;
  logic [PLD_W+1:0]     w_in_data;
  logic [VC_W-1:0]      w_in_vc;
  flit_type_e           w_type;
  logic [C_HDR_W-1:0]   w_hdr;

  // LSB first: dst_x, dst_y, src_x, src_y, len, pkt_id.
  assign w_hdr = {r_pkt_id, msg_len, id_y, id_x, msg_dst_y, msg_dst_x};

  always_comb begin
    w_state_nxt     = r_state;
    w_pkt_id_nxt    = r_pkt_id;
    w_vc_nxt        = r_vc;
    w_remaining_nxt = r_remaining;
    msg_ready       = 1'b0;
    pld_ready       = 1'b0;
    w_in_valid      = 1'b0;
    w_in_vc         = r_vc;
    w_type          = FLIT_HEAD_TAIL;
    w_in_data       = '0;

    case (r_state)
      ST_IDLE: begin
        // VC availability only matters at packet start; the VC stays locked afterwards.
        msg_ready = !noc_rst && w_slot_free && vc_ready[msg_vc];
        if (msg_valid && msg_ready) begin
          w_type          = (msg_len == '0) ? FLIT_HEAD_TAIL : FLIT_HEAD;
          w_in_valid      = 1'b1;
          w_in_vc         = msg_vc;
          w_in_data       = {w_type, PLD_W'(w_hdr)};
          w_vc_nxt        = msg_vc;
          w_remaining_nxt = msg_len;
          w_pkt_id_nxt    = r_pkt_id + PKT_ID_W'(1);
          if (msg_len != '0) begin
            w_state_nxt = ST_BODY;
          end
        end
      end
      ST_BODY: begin
        pld_ready = !noc_rst && w_slot_free;
        if (pld_valid && pld_ready) begin
          w_type          = (r_remaining == LEN_W'(1)) ? FLIT_TAIL : FLIT_BODY;
          w_in_valid      = 1'b1;
          w_in_data       = {w_type, pld_data};
          w_remaining_nxt = r_remaining - LEN_W'(1);
          if (r_remaining == LEN_W'(1)) begin
            w_state_nxt = ST_IDLE;
          end
        end
      end
      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge noc_clk) begin
    if (noc_rst) begin
      r_state     <= ST_IDLE;
      r_pkt_id    <= '0;
      r_vc        <= '0;
      r_remaining <= '0;
    end else begin
      r_state     <= w_state_nxt;
      r_pkt_id    <= w_pkt_id_nxt;
      r_vc        <= w_vc_nxt;
      r_remaining <= w_remaining_nxt;
    end
  end

  noc_flit_out_slice #(
    .DATA_W (PLD_W + 2),
    .VC_W   (VC_W)
  ) u_out_slice (
    .clk     (noc_clk),
    .rst     (noc_rst),
    .i_valid (w_in_valid),
    .o_ready (w_slot_free),
    .i_data  (w_in_data),
    .i_vc    (w_in_vc),
    .o_valid (flit_valid),
    .i_ready (flit_ready),
    .o_data  (flit_data),
    .o_vc    (flit_vc)
  );

  assign busy = (r_state == ST_BODY) || flit_valid;

endmodule

`default_nettype wire
